// File: rtl/alu_acc_stage.sv
// alu_acc_stage
//   Batch accumulator placed after the combinational ALU. Signed ALU results
//   are accepted over a valid/ready handshake and sign-extended into a
//   signed accumulator. After BATCH_LEN accepted results the batch sum is
//   presented on a valid/ready output and held until the consumer takes it.
//   Overflow is tracked with a sticky flag per batch.
//
// Configuration macro:
//   ALU_ACC_SAT_EN  defined   -> accumulator clamps to the signed min/max on overflow
//                   undefined -> accumulator wraps modulo 2^ACC_WIDTH
//
// Parameters:
//   DATA_WIDTH  ALU operand width; the result input is 2*DATA_WIDTH bits
//   ACC_WIDTH   signed accumulator width (>= 2*DATA_WIDTH)
//   BATCH_LEN   results summed per batch (>= 1)
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   alu_result_in  signed ALU result
//   alu_valid_in   alu_result_in valid this cycle
//   alu_ready_out  stage accepts a result this cycle (decoded from state)
//   clear_in       synchronous clear of the partial batch (ignored in EMIT)
//   acc_out        signed accumulator value
//   acc_valid_out  acc_out holds a completed batch sum (decoded from state)
//   acc_ready_in   consumer takes acc_out
//   acc_count_out  results accumulated in the current batch
//   ovf_out        sticky overflow for the current batch

module alu_acc_stage #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 12,
  parameter int BATCH_LEN  = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [2*DATA_WIDTH-1:0]            alu_result_in,
  input  logic                               alu_valid_in,
  output logic                               alu_ready_out,
  input  logic                               clear_in,
  output logic [ACC_WIDTH-1:0]               acc_out,
  output logic                               acc_valid_out,
  input  logic                               acc_ready_in,
  output logic [$clog2(BATCH_LEN+1)-1:0]     acc_count_out,
  output logic                               ovf_out
);

  localparam int RW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(BATCH_LEN + 1);

  localparam logic [CW-1:0]        LAST_CNT = CW'(BATCH_LEN - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q,   acc_d;
  logic [CW-1:0]        cnt_q,   cnt_d;
  logic                 ovf_q,   ovf_d;

  // Sum is formed one bit wider than the accumulator so that overflow is
  // visible as a disagreement between the two top bits.
  logic [ACC_WIDTH:0]   sum;
  logic                 sum_ovf;
  logic [ACC_WIDTH-1:0] acc_nxt;

  always_comb begin
    sum     = {acc_q[ACC_WIDTH-1], acc_q}
            + {{(ACC_WIDTH+1-RW){alu_result_in[RW-1]}}, alu_result_in};
    sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
`ifdef ALU_ACC_SAT_EN
    // The extra top bit carries the true sign, so it picks the clamp direction.
    if (sum_ovf) begin
      acc_nxt = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_nxt = sum[ACC_WIDTH-1:0];
    end
`else
    acc_nxt = sum[ACC_WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    alu_ready_out = 1'b0;
    acc_valid_out = 1'b0;
    unique case (state_q)
      ACCUM: begin
        alu_ready_out = 1'b1;
        if (clear_in) begin
          // Clear wins; a result presented in the same cycle is dropped.
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (alu_valid_in) begin
          acc_d = acc_nxt;
          cnt_d = cnt_q + 1'b1;
          ovf_d = ovf_q | sum_ovf;
          if (cnt_q == LAST_CNT) begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        acc_valid_out = 1'b1;
        if (acc_ready_in) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_out       = acc_q;
  assign acc_count_out = cnt_q;
  assign ovf_out       = ovf_q;

endmodule

// File: tb/tb_alu_acc_stage.sv
module tb_alu_acc_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] res = '0;
  logic       valid = 1'b0;
  logic       clear = 1'b0;
  logic       aready = 1'b0;

  // instance 0: defaults, instance 1: ACC_WIDTH=9, instance 2: BATCH_LEN=1
  logic        rdy0, vld0, ovf0;
  logic [11:0] acc0;
  logic [3:0]  cnt0;
  logic        rdy1, vld1, ovf1;
  logic [8:0]  acc1;
  logic [3:0]  cnt1;
  logic        rdy2, vld2, ovf2;
  logic [11:0] acc2;
  logic [0:0]  cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_acc_stage #(.DATA_WIDTH(4), .ACC_WIDTH(12), .BATCH_LEN(8)) u0 (
    .clk(clk), .rst_n(rst_n), .alu_result_in(res), .alu_valid_in(valid),
    .alu_ready_out(rdy0), .clear_in(clear), .acc_out(acc0), .acc_valid_out(vld0),
    .acc_ready_in(aready), .acc_count_out(cnt0), .ovf_out(ovf0));

  alu_acc_stage #(.DATA_WIDTH(4), .ACC_WIDTH(9), .BATCH_LEN(8)) u1 (
    .clk(clk), .rst_n(rst_n), .alu_result_in(res), .alu_valid_in(valid),
    .alu_ready_out(rdy1), .clear_in(clear), .acc_out(acc1), .acc_valid_out(vld1),
    .acc_ready_in(aready), .acc_count_out(cnt1), .ovf_out(ovf1));

  alu_acc_stage #(.DATA_WIDTH(4), .ACC_WIDTH(12), .BATCH_LEN(1)) u2 (
    .clk(clk), .rst_n(rst_n), .alu_result_in(res), .alu_valid_in(valid),
    .alu_ready_out(rdy2), .clear_in(clear), .acc_out(acc2), .acc_valid_out(vld2),
    .acc_ready_in(aready), .acc_count_out(cnt2), .ovf_out(ovf2));

  // ---------------- behavioural model ----------------
  typedef struct {
    longint acc;
    int     cnt;
    bit     ovf;
    bit     emit;
  } mst_t;

  mst_t m[3];
  int   aw[3] = '{12, 9, 12};
  int   bl[3] = '{8, 8, 1};

  function automatic mst_t step(mst_t c, int w, int n, bit v, longint x, bit clr, bit rd);
    mst_t   r;
    longint s, lim;
    r   = c;
    lim = longint'(1) <<< (w - 1);
    if (c.emit) begin
      if (rd) begin
        r.acc = 0; r.cnt = 0; r.ovf = 0; r.emit = 0;
      end
    end else if (clr) begin
      r.acc = 0; r.cnt = 0; r.ovf = 0;
    end else if (v) begin
      s = c.acc + x;
      if (s >= lim || s < -lim) begin
        r.ovf = 1;
`ifdef ALU_ACC_SAT_EN
        s = (s >= lim) ? lim - 1 : -lim;
`else
        s = s & ((lim <<< 1) - 1);
        if (s >= lim) s = s - (lim <<< 1);
`endif
      end
      r.acc = s;
      r.cnt = c.cnt + 1;
      if (r.cnt == n) r.emit = 1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) m[k] <= '{0, 0, 0, 0};
    end else begin
      for (int k = 0; k < 3; k++)
        m[k] <= step(m[k], aw[k], bl[k], valid, longint'($signed(res)), clear, aready);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input longint a, input bit vl, input bit rd,
                     input longint c, input bit o);
    chk($sformatf("acc[%0d]", k),   a,  m[k].acc);
    chk($sformatf("valid[%0d]", k), longint'(vl), longint'(m[k].emit));
    chk($sformatf("ready[%0d]", k), longint'(rd), longint'(!m[k].emit));
    chk($sformatf("count[%0d]", k), c,  longint'(m[k].cnt));
    chk($sformatf("ovf[%0d]", k),   longint'(o), longint'(m[k].ovf));
  endtask

  // single compare process: every falling edge, all instances vs model
  always @(negedge clk) begin
    cmp(0, longint'($signed(acc0)), vld0, rdy0, longint'(cnt0), ovf0);
    cmp(1, longint'($signed(acc1)), vld1, rdy1, longint'(cnt1), ovf1);
    cmp(2, longint'($signed(acc2)), vld2, rdy2, longint'(cnt2), ovf2);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input int x, input bit clr, input bit rd);
    valid  = v;
    res    = 8'(x);
    clear  = clr;
    aready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = 0; clear = 0; aready = 0; res = '0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    do_reset();
    chk("reset_acc", longint'(acc0), 0);
    chk("reset_ready", longint'(rdy0), 1);
    chk("reset_valid", longint'(vld0), 0);

    // batch 1..8, consumer ready
    for (int i = 1; i <= 8; i++) cyc(1, i, 0, 1);
    chk("b1_acc", longint'($signed(acc0)), 36);
    chk("b1_valid", longint'(vld0), 1);
    chk("b1_count", longint'(cnt0), 8);
    chk("b1_ovf", longint'(ovf0), 0);
    cyc(0, 0, 0, 1);
    chk("b1_after_acc", longint'(acc0), 0);
    chk("b1_after_ready", longint'(rdy0), 1);
    chk("b1_after_valid", longint'(vld0), 0);

    // backpressure hold
    for (int i = 1; i <= 8; i++) cyc(1, i, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 5, 0, 0);
      chk("hold_acc", longint'($signed(acc0)), 36);
      chk("hold_ready", longint'(rdy0), 0);
      chk("hold_count", longint'(cnt0), 8);
    end
    cyc(1, 5, 0, 1);
    chk("release_count", longint'(cnt0), 0);
    chk("release_acc", longint'(acc0), 0);
    cyc(1, 5, 0, 0);
    chk("first_after_acc", longint'($signed(acc0)), 5);
    chk("first_after_count", longint'(cnt0), 1);

    // negative batch
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, -100, 0, 0);
    chk("neg_acc", longint'($signed(acc0)), -800);
    chk("neg_ovf", longint'(ovf0), 0);
    chk("neg_valid", longint'(vld0), 1);

    // overflow on the 9-bit instance
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 64, 0, 1);
    chk("ovf_before", longint'(ovf1), 0);
    cyc(1, 64, 0, 1);
    chk("ovf_4th", longint'(ovf1), 1);
    for (int i = 0; i < 4; i++) cyc(1, 64, 0, 1);
`ifdef ALU_ACC_SAT_EN
    chk("ovf_final_acc", longint'($signed(acc1)), 255);
`else
    chk("ovf_final_acc", longint'($signed(acc1)), 0);
`endif
    chk("ovf_final_flag", longint'(ovf1), 1);
    chk("ovf_final_valid", longint'(vld1), 1);

    // clear with a coincident valid result
    do_reset();
    cyc(1, 3, 0, 0);
    chk("bl1_valid", longint'(vld2), 1);
    chk("bl1_acc", longint'($signed(acc2)), 3);
    chk("bl1_count", longint'(cnt2), 1);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 7, 0, 1);
    chk("pre_clear_acc", longint'($signed(acc0)), 21);
    cyc(1, 9, 1, 1);
    chk("clear_acc", longint'(acc0), 0);
    chk("clear_count", longint'(cnt0), 0);
    for (int i = 0; i < 8; i++) cyc(1, 2, 0, 0);
    chk("clear_sum", longint'($signed(acc0)), 16);
    chk("clear_sum_count", longint'(cnt0), 8);

    // asynchronous reset in EMIT
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1, i, 0, 0);
    chk("emit_pre_acc", longint'($signed(acc0)), 36);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", longint'(vld0), 0);
    chk("async_acc", longint'(acc0), 0);
    #3;
    rst_n = 1'b1;
    valid = 0;
    @(posedge clk);
    #1;
    chk("async_ready", longint'(rdy0), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 401 == 400) begin
        do_reset();
      end else begin
        cyc(($urandom_range(3) != 0), int'($urandom_range(255)),
            ($urandom_range(15) == 0), ($urandom_range(1) == 1));
      end
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
